// File: rtl/clk_gate_ctrl.sv
// CE sequencer for a DHCEN clock-gate primitive: wakes, drains and stops a gated domain safely.
// Optional auto-sleep on prolonged idle is enabled by defining CLK_GATE_AUTO_SLEEP_EN.
module clk_gate_ctrl #(
  parameter int unsigned WAKE_CYCLES  = 4,
  parameter int unsigned DRAIN_CYCLES = 8,
  parameter int unsigned STOP_CYCLES  = 4,
  parameter int unsigned IDLE_TIMEOUT = 1024
) (
  input  logic clk,
  input  logic reset,
  input  logic run_req,
  input  logic domain_idle,
  input  logic wake_evt,
  output logic dhcen_ce,
  output logic clk_active,
  output logic busy
);

  localparam int unsigned CNT_W  = 8;
  localparam int unsigned IDLE_W = 16;

  localparam logic [CNT_W-1:0] WAKE_LOAD  = CNT_W'(WAKE_CYCLES - 1);
  localparam logic [CNT_W-1:0] DRAIN_LOAD = CNT_W'(DRAIN_CYCLES - 1);
  localparam logic [CNT_W-1:0] STOP_LOAD  = CNT_W'(STOP_CYCLES - 1);

  typedef enum logic [2:0] {
    S_OFF,
    S_WAKE,
    S_ON,
    S_DRAIN,
    S_STOP
`ifdef CLK_GATE_AUTO_SLEEP_EN
    , S_SLEEP
`endif
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             w_cnt_zero;
  logic             w_drain_abort;
  logic             r_ce;
  logic             r_active;
  logic             r_busy;
  logic             w_ce_nxt;
  logic             w_active_nxt;
  logic             w_busy_nxt;

`ifdef CLK_GATE_AUTO_SLEEP_EN
  localparam logic [IDLE_W-1:0] IDLE_LIMIT = IDLE_W'(IDLE_TIMEOUT);

  logic [IDLE_W-1:0] r_idle_cnt;
  logic [IDLE_W-1:0] w_idle_nxt;
  logic [IDLE_W-1:0] w_idle_inc;
  logic              r_sleep_pend;
  logic              w_pend_nxt;

  assign w_idle_inc    = r_idle_cnt + IDLE_W'(1);
  // An auto-sleep drain is not cancelled by run_req, which is still high by definition.
  assign w_drain_abort = run_req && !r_sleep_pend;
`else
  logic              w_unused_wake;
  logic [IDLE_W-1:0] w_unused_idle_timeout;

  assign w_unused_wake         = wake_evt;
  assign w_unused_idle_timeout = IDLE_W'(IDLE_TIMEOUT);
  assign w_drain_abort         = run_req;
`endif

  assign w_cnt_zero = (r_cnt == '0);

  // Next-state, shared counter and next-output decode.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
`ifdef CLK_GATE_AUTO_SLEEP_EN
    w_idle_nxt  = '0;
    w_pend_nxt  = r_sleep_pend;
`endif

    case (r_state)
      S_OFF: begin
        if (run_req) begin
          w_state_nxt = S_WAKE;
          w_cnt_nxt   = WAKE_LOAD;
        end
      end
      S_WAKE: begin
        if (w_cnt_zero) w_state_nxt = S_ON;
        else            w_cnt_nxt   = r_cnt - CNT_W'(1);
      end
      S_ON: begin
        if (!run_req) begin
          w_state_nxt = S_DRAIN;
          w_cnt_nxt   = DRAIN_LOAD;
`ifdef CLK_GATE_AUTO_SLEEP_EN
          w_pend_nxt  = 1'b0;
        end else if (domain_idle) begin
          if (w_idle_inc == IDLE_LIMIT) begin
            w_state_nxt = S_DRAIN;
            w_cnt_nxt   = DRAIN_LOAD;
            w_pend_nxt  = 1'b1;
          end else begin
            w_idle_nxt  = w_idle_inc;
          end
`endif
        end
      end
      S_DRAIN: begin
`ifdef CLK_GATE_AUTO_SLEEP_EN
        if (!run_req) w_pend_nxt = 1'b0;
`endif
        if (w_drain_abort) begin
          w_state_nxt = S_ON;
        end else if (!domain_idle) begin
          w_cnt_nxt   = DRAIN_LOAD;
        end else if (w_cnt_zero) begin
          w_state_nxt = S_STOP;
          w_cnt_nxt   = STOP_LOAD;
        end else begin
          w_cnt_nxt   = r_cnt - CNT_W'(1);
        end
      end
      S_STOP: begin
        if (w_cnt_zero) begin
`ifdef CLK_GATE_AUTO_SLEEP_EN
          w_state_nxt = r_sleep_pend ? S_SLEEP : S_OFF;
          w_pend_nxt  = 1'b0;
`else
          w_state_nxt = S_OFF;
`endif
        end else begin
          w_cnt_nxt   = r_cnt - CNT_W'(1);
        end
      end
`ifdef CLK_GATE_AUTO_SLEEP_EN
      S_SLEEP: begin
        if (!run_req) begin
          w_state_nxt = S_OFF;
        end else if (wake_evt) begin
          w_state_nxt = S_WAKE;
          w_cnt_nxt   = WAKE_LOAD;
        end
      end
`endif
      default: begin
        w_state_nxt = S_OFF;
        w_cnt_nxt   = '0;
      end
    endcase

    // Outputs follow the state being entered so they register together with it.
    w_ce_nxt     = 1'b1;
    w_active_nxt = 1'b0;
    w_busy_nxt   = 1'b0;
    case (w_state_nxt)
      S_WAKE:  begin w_ce_nxt = 1'b0; w_busy_nxt = 1'b1; end
      S_ON:    begin w_ce_nxt = 1'b0; w_active_nxt = 1'b1; end
      S_DRAIN: begin w_ce_nxt = 1'b0; w_busy_nxt = 1'b1; end
      S_STOP:  begin w_busy_nxt = 1'b1; end
      default: begin end
    endcase
  end

  // State, counter and output registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state  <= S_OFF;
      r_cnt    <= '0;
      r_ce     <= 1'b1;
      r_active <= 1'b0;
      r_busy   <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_cnt    <= w_cnt_nxt;
      r_ce     <= w_ce_nxt;
      r_active <= w_active_nxt;
      r_busy   <= w_busy_nxt;
    end
  end

`ifdef CLK_GATE_AUTO_SLEEP_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_idle_cnt   <= '0;
      r_sleep_pend <= 1'b0;
    end else begin
      r_idle_cnt   <= w_idle_nxt;
      r_sleep_pend <= w_pend_nxt;
    end
  end
`endif

  assign dhcen_ce   = r_ce;
  assign clk_active = r_active;
  assign busy       = r_busy;

endmodule

// File: tb/tb_clk_gate_ctrl.sv
// Scoreboard bench for clk_gate_ctrl (default build): a deadline-based reference model
// predicts {dhcen_ce, clk_active, busy} after every edge; a monitor checks them.
module tb_clk_gate_ctrl;

  localparam int unsigned W = 4;
  localparam int unsigned D = 8;
  localparam int unsigned S = 4;
  localparam int unsigned I = 1024;

  localparam int M_OFF   = 0;
  localparam int M_WAKE  = 1;
  localparam int M_ON    = 2;
  localparam int M_DRAIN = 3;
  localparam int M_STOP  = 4;

  typedef struct {
    logic [2:0] exp;
    int         tag;
    int         cyc;
  } exp_t;

  logic clk;
  logic reset;
  logic run_req;
  logic domain_idle;
  logic wake_evt;
  logic dhcen_ce;
  logic clk_active;
  logic busy;

  exp_t exp_q[$];
  int   total;
  int   bad;

  int   mode;
  int   cyc;
  int   t_dead;
  int   idle_run;

  clk_gate_ctrl #(
    .WAKE_CYCLES (W),
    .DRAIN_CYCLES(D),
    .STOP_CYCLES (S),
    .IDLE_TIMEOUT(I)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .run_req    (run_req),
    .domain_idle(domain_idle),
    .wake_evt   (wake_evt),
    .dhcen_ce   (dhcen_ce),
    .clk_active (clk_active),
    .busy       (busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic string tag_name(input int t);
    case (t)
      0:       return "reset_idle";
      1:       return "start";
      2:       return "drain_reload";
      3:       return "drain_abort";
      4:       return "drain_busy_entry";
      5:       return "reset_in_wake";
      default: return "random";
    endcase
  endfunction

  function automatic logic [2:0] model_outs(input int m);
    logic ce, act, bsy;
    ce  = (m == M_OFF) || (m == M_STOP);
    act = (m == M_ON);
    bsy = (m == M_WAKE) || (m == M_DRAIN) || (m == M_STOP);
    return {ce, act, bsy};
  endfunction

  // One source-clock cycle: drive at negedge, advance the model to the next edge, queue the outcome.
  task automatic step(input logic rr, input logic di, input logic rst, input int tag);
    exp_t e;
    @(negedge clk);
    run_req     = rr;
    domain_idle = di;
    reset       = rst;
    if (rst) begin
      #1;
      total++;
      if ({dhcen_ce, clk_active, busy} != 3'b100) begin
        bad++;
        $display("FAIL async_reset cyc=%0d got ce/act/busy=%b want=100", cyc, {dhcen_ce, clk_active, busy});
      end
    end
    cyc++;
    if (rst) begin
      mode = M_OFF;
    end else begin
      case (mode)
        M_OFF:   if (rr) begin mode = M_WAKE; t_dead = cyc + int'(W); end
        M_WAKE:  if (cyc == t_dead) mode = M_ON;
        M_ON:    if (!rr) begin mode = M_DRAIN; idle_run = 0; end
        M_DRAIN: begin
          if (rr) mode = M_ON;
          else if (!di) idle_run = 0;
          else begin
            idle_run++;
            if (idle_run == int'(D)) begin mode = M_STOP; t_dead = cyc + int'(S); end
          end
        end
        M_STOP:  if (cyc == t_dead) mode = M_OFF;
        default: mode = M_OFF;
      endcase
    end
    e.exp = model_outs(mode);
    e.tag = tag;
    e.cyc = cyc;
    exp_q.push_back(e);
  endtask

  // Monitor: checks each queued expectation just after the edge it belongs to.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        total++;
        if ({dhcen_ce, clk_active, busy} !== e.exp) begin
          bad++;
          $display("FAIL %s cyc=%0d got ce/act/busy=%b want=%b", tag_name(e.tag), e.cyc,
                   {dhcen_ce, clk_active, busy}, e.exp);
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $display("test done: total=%0d bad=%0d", total, bad + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    logic rr;
    logic di;
    logic rst;
    total       = 0;
    bad         = 0;
    mode        = M_OFF;
    cyc         = 0;
    t_dead      = 0;
    idle_run    = 0;
    reset       = 1'b1;
    run_req     = 1'b0;
    domain_idle = 1'b1;
    wake_evt    = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    total++;
    if ({dhcen_ce, clk_active, busy} !== 3'b100) begin
      bad++;
      $display("FAIL reset_state got ce/act/busy=%b want=100", {dhcen_ce, clk_active, busy});
    end

    repeat (20) step(1'b0, 1'b1, 1'b0, 0);
    repeat (10) step(1'b1, 1'b1, 1'b0, 1);

    step(1'b0, 1'b1, 1'b0, 2);
    repeat (4) step(1'b0, 1'b1, 1'b0, 2);
    step(1'b0, 1'b0, 1'b0, 2);
    repeat (14) step(1'b0, 1'b1, 1'b0, 2);

    repeat (6) step(1'b1, 1'b1, 1'b0, 3);
    repeat (3) step(1'b0, 1'b1, 1'b0, 3);
    repeat (3) step(1'b1, 1'b1, 1'b0, 3);

    repeat (5) step(1'b0, 1'b0, 1'b0, 4);
    repeat (14) step(1'b0, 1'b1, 1'b0, 4);

    repeat (2) step(1'b1, 1'b1, 1'b0, 5);
    step(1'b1, 1'b1, 1'b1, 5);
    repeat (4) step(1'b0, 1'b1, 1'b0, 5);

    rr = 1'b0;
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 15) == 0) rr = ~rr;
      di  = ($urandom_range(0, 9) != 0);
      rst = ($urandom_range(0, 399) == 0);
      step(rr, di, rst, 6);
    end

    for (int k = 0; k < 10 && exp_q.size() != 0; k++) @(negedge clk);
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL drain_queue got pending=%0d want=0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
